// File: rtl/div_pkg.sv
// Shared types and constants for the sequential divider.
package div_pkg;
  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } state_t;
endpackage

// File: rtl/sub_borrow.sv
// WIDTH-bit subtractor a-b with borrow out; the trial step of the divider.
module sub_borrow #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);
  assign {borrow, diff} = {1'b0, a} - {1'b0, b};
endmodule

// File: rtl/div_seq.sv
// Restoring sequential divider: one quotient bit per cycle, fixed latency.
// Build option DIV_SEQ_SIGNED_EN selects two's-complement operands.
module div_seq
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH + 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem, quo, dvs;
  logic             neg_q, neg_r;

  logic [WIDTH-1:0] mag_a, mag_b;
  logic             sgn_a, sgn_b;

  always_comb begin
`ifdef DIV_SEQ_SIGNED_EN
    sgn_a = dividend[WIDTH-1];
    sgn_b = divisor[WIDTH-1];
    mag_a = sgn_a ? -dividend : dividend;
    mag_b = sgn_b ? -divisor : divisor;
`else
    sgn_a = 1'b0;
    sgn_b = 1'b0;
    mag_a = dividend;
    mag_b = divisor;
`endif
  end

  // Shifted partial remainder; its dropped MSB means the trial always succeeds.
  logic [WIDTH-1:0] shifted, diff;
  logic             borrow, take;

  assign shifted = {rem[WIDTH-2:0], quo[WIDTH-1]};
  assign take    = rem[WIDTH-1] | ~borrow;

  sub_borrow #(.WIDTH(WIDTH)) u_sub (
    .a      (shifted),
    .b      (dvs),
    .diff   (diff),
    .borrow (borrow)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      rem         <= '0;
      quo         <= '0;
      dvs         <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy        <= 1'b1;
            div_by_zero <= (divisor == '0);
            if (divisor == '0) begin
              quo   <= '0;
              rem   <= dividend;
              neg_q <= 1'b0;
              neg_r <= 1'b0;
              state <= DONE;
            end else begin
              quo   <= mag_a;
              rem   <= '0;
              dvs   <= mag_b;
              neg_q <= sgn_a ^ sgn_b;
              neg_r <= sgn_a;
              cnt   <= CW'(WIDTH);
              state <= CALC;
            end
          end
        end
        CALC: begin
          rem <= take ? diff : shifted;
          quo <= {quo[WIDTH-2:0], take};
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) state <= FIXUP;
        end
        FIXUP: begin
          quo   <= neg_q ? -quo : quo;
          rem   <= neg_r ? -rem : rem;
          state <= DONE;
        end
        DONE: begin
          done      <= 1'b1;
          busy      <= 1'b0;
          quotient  <= quo;
          remainder <= rem;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/div_seq.md
DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width in bits (legal 4..64).
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-004 start  input  1  request a division; sampled only in IDLE.
REQ-005 dividend  input  WIDTH  numerator; captured on accepted start.
REQ-006 divisor  input  WIDTH  denominator; captured on accepted start.
REQ-007 busy  output  1  high from the cycle after an accepted start until done.
REQ-008 done  output  1  single-cycle pulse marking valid results.
REQ-009 quotient  output  WIDTH  quotient; held stable until the next accepted start.
REQ-010 remainder  output  WIDTH  remainder; held stable until the next accepted start.
REQ-011 div_by_zero  output  1  high with done when the captured divisor was 0; held with the results.

Function
REQ-012 FSM states SHALL be IDLE, CALC, FIXUP and DONE.
REQ-013 IDLE with start=1 and divisor!=0 SHALL capture the operands, load the iteration counter with WIDTH, and go to CALC.
REQ-014 IDLE with start=1 and divisor==0 SHALL go directly to DONE with quotient=0, remainder=dividend and div_by_zero=1.
REQ-015 CALC SHALL run one restoring step per cycle for exactly WIDTH cycles.
REQ-016 Each CALC step SHALL shift {rem,quo} left by 1, form trial=rem-divisor, keep trial if there is no borrow (quotient bit 1), else restore (quotient bit 0).
REQ-017 After the last CALC step the FSM SHALL enter FIXUP for exactly one cycle, then DONE.
REQ-018 DONE SHALL assert done for one cycle and return to IDLE unconditionally.
REQ-019 Latency SHALL be fixed: an accepted start at edge N gives done high in the cycle after edge N+WIDTH+2; a divide-by-zero start gives done in the cycle after edge N+1.
REQ-020 start SHALL be ignored in CALC, FIXUP and DONE, with no effect on the operation in progress.
REQ-021 Operand inputs SHALL be don't-care outside the cycle of an accepted start.
REQ-022 div_by_zero SHALL clear on the next accepted start.

Reset
REQ-023 reset_n low SHALL force IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0 and counter=0, independent of clock.
REQ-024 Reset asserted mid-CALC SHALL abandon the operation with no done pulse; the first start after release SHALL be served normally.

Configuration
REQ-025 Macro DIV_SEQ_SIGNED_EN defined: operands are two's complement.
- CALC operates on magnitudes.
- FIXUP negates the quotient when the operand signs differ, and negates the remainder when the dividend is negative.
- Quotient truncates toward zero.
- Most-negative / -1 SHALL give quotient=most-negative and remainder=0, with no flag.
REQ-026 Macro DIV_SEQ_SIGNED_EN undefined: operands are unsigned and FIXUP passes the results through unchanged; latency is identical in both builds.

Structure
REQ-027 Shared package div_pkg SHALL hold the FSM state typedef (IDLE, CALC, FIXUP, DONE) and the default-width constant DIV_WIDTH=32.
REQ-028 The trial subtraction SHALL be a sub-module sub_borrow (WIDTH-bit a-b producing diff and borrow out), instantiated once in div_seq.

Verification (WIDTH=32)
REQ-029 Case 1 (either build): 100/7 with start at edge 0 -> busy for cycles 1..34, done pulse in cycle 35, quotient=14, remainder=2, div_by_zero=0.
REQ-030 Case 2 (either build): 55/0 -> done pulse the cycle after edge 1, div_by_zero=1, quotient=0, remainder=55; the next 9/3 start -> div_by_zero=0, quotient=3, remainder=0.
REQ-031 Case 3 (signed build): 0xFFFFFFF9/2 (-7/2) -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF; 7/0xFFFFFFFE -> quotient=0xFFFFFFFD, remainder=1.
REQ-032 Case 4: 0x80000000/0xFFFFFFFF -> signed build quotient=0x80000000, remainder=0; unsigned build quotient=0, remainder=0x80000000.
REQ-033 Case 5 (either build): pulse start with 1000/10 ten cycles into a running 100/7 -> single done, results 14/2; reset_n low at cycle 20 of a new operation -> all outputs 0 and no done; then 0xFFFFFFFF/1 -> quotient=0xFFFFFFFF, remainder=0.
